// File: rtl/uart_rx_frame_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_rx_pkg;

    // Width of the bit index counter; holds DATA_BITS up to 8 without wrapping.
    localparam int BIT_CNT_W = 4;

    // Idle level of the serial line, used as the synchronizer reset value.
    localparam logic SYNC_RESET_VAL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        RECV,
        STOP_CHK,
        STORE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_flex_counter.sv
// Team flex_counter: clearable up-counter that wraps from rollover_val back to 1
// and raises rollover_flag while the count equals rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;

    // Next count: clear has priority, otherwise step and wrap to 1 after rollover_val.
    always_comb begin
        count_d = count_q;
        flag_d  = flag_q;
        if (clear) begin
            count_d = '0;
            flag_d  = 1'b0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
            flag_d = (count_d == rollover_val);
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver. Synchronizes the serial line, validates
// the start bit at mid-bit, shifts in DATA_BITS LSB-first, checks the stop bit and
// presents the byte on a level-held ready/read handshake.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT) + 1;

    // The timer restarts from 0 on every state entry and every sample, so a sample
    // falls on the last count of each window and the rollover value is never reached.
    localparam logic [TIMER_W-1:0]   TIMER_ROLL = TIMER_W'(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0]   HALF_LAST  = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0]   FULL_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ROLL   = BIT_CNT_W'(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(DATA_BITS - 1);

    logic sync1_q, sync2_q, sync_prev_q;
    logic sync, start_edge;

    rx_state_e state_q, state_d;

    logic [TIMER_W-1:0]   timer_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 timer_clear, timer_en;
    logic                 bit_clear, bit_en;
    logic                 timer_roll_unused, bit_roll_unused;

    logic sample_strobe, store_now, frame_bad;

    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 ready_q, ready_d;
    logic                 overrun_q, overrun_d;
    logic                 framing_q, framing_d;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q     <= SYNC_RESET_VAL;
            sync2_q     <= SYNC_RESET_VAL;
            sync_prev_q <= SYNC_RESET_VAL;
        end else begin
            sync1_q     <= serial_in;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
        end
    end

    assign sync       = sync2_q;
    assign start_edge = sync_prev_q & ~sync2_q;

    // Sample at mid start bit, then once per full bit period for data and stop bits.
    always_comb begin
        sample_strobe = 1'b0;
        case (state_q)
            START_CHK:      sample_strobe = (timer_cnt == HALF_LAST);
            RECV, STOP_CHK: sample_strobe = (timer_cnt == FULL_LAST);
            default:        sample_strobe = 1'b0;
        endcase
    end

    // Frame sequencing; STORE is a one-cycle guard before a new start edge is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_edge) state_d = START_CHK;
            end
            START_CHK: begin
                if (sample_strobe) state_d = sync ? IDLE : RECV;
            end
            RECV: begin
                if (sample_strobe && (bit_cnt == LAST_BIT)) state_d = STOP_CHK;
            end
            STOP_CHK: begin
                if (sample_strobe) state_d = sync ? STORE : IDLE;
            end
            STORE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The timer is held cleared in IDLE, so it starts fresh from the start edge.
    assign timer_en    = (state_q != IDLE);
    assign timer_clear = (state_q == IDLE) | (state_d != state_q) | sample_strobe;
    assign bit_clear   = (state_q == START_CHK) & sample_strobe & ~sync;
    assign bit_en      = (state_q == RECV) & sample_strobe;
    assign store_now   = (state_q == STOP_CHK) & sample_strobe & sync;
    assign frame_bad   = (state_q == STOP_CHK) & sample_strobe & ~sync;

    flex_counter #(
        .NUM_CNT_BITS(TIMER_W)
    ) u_bit_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (timer_clear),
        .count_enable (timer_en),
        .rollover_val (TIMER_ROLL),
        .count_out    (timer_cnt),
        .rollover_flag(timer_roll_unused)
    );

    flex_counter #(
        .NUM_CNT_BITS(BIT_CNT_W)
    ) u_bit_index (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (bit_clear),
        .count_enable (bit_en),
        .rollover_val (BIT_ROLL),
        .count_out    (bit_cnt),
        .rollover_flag(bit_roll_unused)
    );

    // Shift register and output handshake; the byte is committed on the edge that
    // enters STORE, and a coincident data_read loses to the new byte.
    always_comb begin
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        framing_d = framing_q;

        if (bit_en) begin
            shift_d = {sync, shift_q[DATA_BITS-1:1]};
        end

        if (store_now) begin
            rx_data_d = shift_q;
            ready_d   = 1'b1;
            overrun_d = data_read ? 1'b0 : (overrun_q | ready_q);
        end else if (data_read && ready_q) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if ((state_q == IDLE) && start_edge) begin
            framing_d = 1'b0;
        end else if (frame_bad) begin
            framing_d = 1'b1;
        end
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            framing_q <= framing_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;

endmodule
